mult_sched: RTL and testbench

//   Round-robin scheduler sharing one sequential shift-add multiplier among NREQ requesters.

---
 rtl/mult_sched_pkg.sv | 36 +++
 rtl/mult_sched_rr_arbiter.sv | 29 ++
 rtl/mult_sched.sv | 142 ++++++++++++++
 tb/tb_mult_sched.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_sched_pkg.sv
// Shared types and helpers for the round-robin multiplier scheduler.
package mult_sched_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int NREQ_DEF  = 4;
    localparam int HALF      = WIDTH_DEF / 2;
    localparam int OWN_W     = $clog2(NREQ_DEF);
    // Widest requester vector rr_pick can search.
    localparam int MAXREQ    = 32;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CLEAR,
        RUN,
        RESP
    } state_t;

    // One-hot pick of the first set bit of req, searching upward from ptr
    // and wrapping at n. Returns zero when no bit in [0, n) is set.
    function automatic logic [MAXREQ-1:0] rr_pick(input logic [MAXREQ-1:0] req,
                                                  input int unsigned       ptr,
                                                  input int unsigned       n);
        logic [MAXREQ-1:0] g;
        int unsigned       idx;
        g = '0;
        for (int unsigned k = 0; k < MAXREQ; k++) begin
            idx = (ptr + k) % n;
            if (k < n && g == '0 && req[idx[4:0]]) begin
                g[idx[4:0]] = 1'b1;
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/mult_sched_rr_arbiter.sv
// Combinational round-robin arbiter; the pointer register is owned by the caller.
module rr_arbiter
    import mult_sched_pkg::*;
#(
    parameter int NREQ = 4,
    localparam int OW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [OW-1:0]   ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [OW-1:0]   idx
);

    // Grant the first requester at or after ptr, then encode its index.
    always_comb begin
        gnt = '0;
        idx = '0;
        if (en) begin
            gnt = NREQ'(rr_pick(MAXREQ'(req), 32'(ptr), NREQ));
        end
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                idx = OW'(i);
            end
        end
    end

endmodule

// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one sequential multiplier among NREQ requesters,
// with a watchdog that aborts a multiplier that never raises done.
module mult_sched
    import mult_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64,
    localparam int H      = WIDTH / 2,
    localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW     = $clog2(TIMEOUT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*H-1:0] req_a,
    input  logic [NREQ*H-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [WIDTH-1:0]  rsp_result,
    output logic              rsp_err,
    output logic [H-1:0]      mul_a,
    output logic [H-1:0]      mul_b,
    output logic              mul_start,
    input  logic [WIDTH-1:0]  mul_result,
    input  logic              mul_done,
    output logic              busy,
    output logic              err_sticky
);

    state_t          state, state_nxt;
    logic [OW-1:0]   ptr;
    logic [OW-1:0]   owner;
    logic [CW-1:0]   wd_cnt;
    logic            err_r;
    logic [NREQ-1:0] gnt;
    logic [OW-1:0]   gidx;
    logic            accept;
    logic            timeout_hit;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req (req_valid),
        .ptr (ptr),
        .en  (state == IDLE),
        .gnt (gnt),
        .idx (gidx)
    );

    // The arbiter only grants a valid requester, so any grant is a transfer.
    assign accept      = |gnt;
    assign req_ready   = gnt;
    assign timeout_hit = (wd_cnt == CW'(TIMEOUT - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic and the state-decoded outputs. A done seen in the same
    // cycle as the watchdog limit wins over the abort.
    always_comb begin
        state_nxt = state;
        rsp_valid = '0;
        rsp_err   = 1'b0;
        mul_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE:  if (accept) state_nxt = ISSUE;
            ISSUE: begin
                mul_start = 1'b1;
                state_nxt = CLEAR;
            end
            CLEAR: begin
                if (!mul_done)        state_nxt = RUN;
                else if (timeout_hit) state_nxt = RESP;
            end
            RUN: begin
                if (mul_done || timeout_hit) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = NREQ'(1) << owner;
                rsp_err   = err_r;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, owner/pointer bookkeeping, watchdog and result latch.
    // Operands stay untouched outside the accept so the multiplier sees them stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr        <= '0;
            owner      <= '0;
            wd_cnt     <= '0;
            err_r      <= 1'b0;
            err_sticky <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            rsp_result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a <= req_a[int'(gidx)*H +: H];
                        mul_b <= req_b[int'(gidx)*H +: H];
                        owner <= gidx;
                        ptr   <= (gidx == OW'(NREQ - 1)) ? '0 : gidx + OW'(1);
                    end
                end
                ISSUE: begin
                    wd_cnt <= '0;
                    err_r  <= 1'b0;
                end
                CLEAR: begin
                    wd_cnt <= wd_cnt + CW'(1);
                    if (mul_done && timeout_hit) begin
                        rsp_result <= '0;
                        err_r      <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                RUN: begin
                    wd_cnt <= wd_cnt + CW'(1);
                    if (mul_done) begin
                        rsp_result <= mul_result;
                    end else if (timeout_hit) begin
                        rsp_result <= '0;
                        err_r      <= 1'b1;
                        err_sticky <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: behavioural shift-add multiplier, scoreboard of
// expected responses keyed by grant, table of operand vectors and corner sequences.
module tb_mult_sched;

    localparam int WIDTH   = 32;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int HALF    = WIDTH / 2;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 mul_rst;
    logic                 hang;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ*HALF-1:0] req_a, req_b;
    logic [NREQ-1:0]      req_ready, rsp_valid;
    logic [WIDTH-1:0]     rsp_result, mul_result;
    logic                 rsp_err, mul_start, mul_done, busy, err_sticky;
    logic [HALF-1:0]      mul_a, mul_b;

    logic [HALF-1:0] op_a [NREQ];
    logic [HALF-1:0] op_b [NREQ];

    always #5 clk = ~clk;

    always_comb begin
        req_a = {op_a[3], op_a[2], op_a[1], op_a[0]};
        req_b = {op_b[3], op_b[2], op_b[1], op_b[0]};
    end

    mult_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .rsp_valid  (rsp_valid),
        .rsp_result (rsp_result),
        .rsp_err    (rsp_err),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_start  (mul_start),
        .mul_result (mul_result),
        .mul_done   (mul_done),
        .busy       (busy),
        .err_sticky (err_sticky)
    );

    // Shift-add multiplier: done rises HALF edges after the start edge.
    // With hang set it finishes but never raises done.
    logic [WIDTH-1:0] m_acc, m_mc;
    logic [HALF-1:0]  m_mp;
    int               m_cnt;
    logic             m_busy;
    always @(posedge clk) begin
        if (mul_rst) begin
            m_acc <= '0; m_mc <= '0; m_mp <= '0; m_cnt <= 0; m_busy <= 1'b0; mul_done <= 1'b0;
        end else if (mul_start) begin
            m_acc <= '0; m_mc <= {{HALF{1'b0}}, mul_a}; m_mp <= mul_b;
            m_cnt <= HALF; m_busy <= 1'b1; mul_done <= 1'b0;
        end else if (m_busy) begin
            if (m_mp[0]) m_acc <= m_acc + m_mc;
            m_mc  <= m_mc << 1;
            m_mp  <= m_mp >> 1;
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_busy   <= 1'b0;
                mul_done <= !hang;
            end
        end
    end
    assign mul_result = m_acc;

    typedef struct {
        int          owner;
        logic [31:0] res;
        logic        err;
    } exp_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] exp;
    } vec_t;

    exp_t        sbq[$];
    int          grant_log[$];
    vec_t        vt[6];
    int          n_pass = 0, n_total = 0;
    int          cyc = 0, rsp_cnt = 0;
    int          last_acc_cyc = 0, last_rsp_cyc = 0;
    logic [31:0] last_res = '0;
    logic [NREQ-1:0] one_shot;
    logic        expect_err;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    // One clock: sample the cycle's grant/response, cross the edge, then
    // retire one-shot requests once their transfer has happened.
    task automatic step();
        int   g;
        exp_t e;
        g = -1;
        #1;
        if (|(req_ready & req_valid)) begin
            chk("grant_onehot", 64'($onehot(req_ready)), 64'd1);
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) g = i;
            e.owner = g;
            e.err   = expect_err;
            e.res   = expect_err ? 32'd0 : 32'(op_a[g]) * 32'(op_b[g]);
            sbq.push_back(e);
            grant_log.push_back(g);
            last_acc_cyc = cyc;
        end
        if (|rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = cyc;
            last_res     = rsp_result;
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 64'(rsp_valid), 64'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_owner",  64'(rsp_valid),  64'(4'b0001 << e.owner));
                chk("rsp_result", 64'(rsp_result), 64'(e.res));
                chk("rsp_err",    64'(rsp_err),    64'(e.err));
            end
        end
        @(negedge clk);
        cyc++;
        if (g >= 0 && one_shot[g]) req_valid[g] = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while ((busy || sbq.size() != 0 || req_valid != '0) && n < lim);
        if (n >= lim) begin
            n_total++;
            $display("FAIL drain_timeout: still busy after %0d cycles, %0d responses pending", n, sbq.size());
        end
    endtask

    task automatic req1(input int r, input int a, input int b);
        op_a[r]      = 16'(a);
        op_b[r]      = 16'(b);
        one_shot[r]  = 1'b1;
        req_valid[r] = 1'b1;
    endtask

    task automatic wait_grant(input int base);
        int n;
        n = 0;
        while (grant_log.size() <= base && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) begin
            n_total++;
            $display("FAIL wait_grant: no grant within %0d cycles", n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, r0;
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        vt[0] = '{16'd3,      16'd5,      32'd15};
        vt[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001};
        vt[2] = '{16'd0,      16'h1234,   32'd0};
        vt[3] = '{16'd1,      16'd1,      32'd1};
        vt[4] = '{16'hFFFF,   16'd1,      32'h0000FFFF};
        vt[5] = '{16'h8000,   16'd2,      32'h00010000};

        reset = 1'b1; mul_rst = 1'b1; hang = 1'b0; expect_err = 1'b0;
        req_valid = '0; one_shot = '0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = '0; op_b[i] = '0; end
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ctrl", 64'({busy, rsp_valid, rsp_err, mul_start, err_sticky, req_ready}), 64'd0);
        chk("reset_operands", 64'({mul_a, mul_b}), 64'd0);
        chk("reset_result", 64'(rsp_result), 64'd0);
        @(negedge clk);
        reset = 1'b0; mul_rst = 1'b0;

        // Single request: same-cycle ready, product, latency.
        req1(0, 3, 5);
        #1;
        chk("t1_ready_same_cycle", 64'(req_ready), 64'b0001);
        drain(100);
        chk("t1_result", 64'(last_res), 64'd15);
        chk("t1_latency", 64'(last_rsp_cyc - last_acc_cyc), 64'(3 + HALF));

        // Operand table through requester 0.
        for (int v = 0; v < 6; v++) begin
            req1(0, int'(vt[v].a), int'(vt[v].b));
            drain(100);
            chk("vec_result", 64'(last_res), 64'(vt[v].exp));
        end

        // Requester 3 wraps the pointer back to 0.
        req1(3, 1, 1);
        drain(100);
        chk("wrap_grant3", 64'(grant_log[$]), 64'd3);

        // All requesting continuously: rotation 0,1,2,3,0 with one response each.
        base = grant_log.size();
        r0   = rsp_cnt;
        one_shot = '0;
        for (int i = 0; i < NREQ; i++) begin op_a[i] = 16'(i + 1); op_b[i] = 16'd100; end
        req_valid = '1;
        begin
            int n;
            n = 0;
            while (grant_log.size() < base + 5 && n < 300) begin step(); n++; end
        end
        req_valid = '0;
        drain(100);
        for (int i = 0; i < 5; i++) begin
            if (base + i < grant_log.size()) chk("rr_order", 64'(grant_log[base + i]), 64'(exp_order[i]));
            else chk("rr_order_missing", 64'(grant_log.size()), 64'(base + 5));
        end
        chk("rr_rsp_count", 64'(rsp_cnt - r0), 64'd5);

        // Hung multiplier: watchdog abort, then normal service.
        chk("sticky_before", 64'(err_sticky), 64'd0);
        hang = 1'b1; expect_err = 1'b1;
        req1(2, 7, 9);
        drain(200);
        chk("wd_latency", 64'(last_rsp_cyc - last_acc_cyc), 64'(TIMEOUT + 2));
        chk("wd_sticky", 64'(err_sticky), 64'd1);
        hang = 1'b0; expect_err = 1'b0;
        req1(2, 6, 7);
        drain(100);
        chk("wd_recover", 64'(last_res), 64'd42);
        chk("wd_sticky_holds", 64'(err_sticky), 64'd1);

        // Reset while in RUN: abort with no response.
        base = grant_log.size();
        req1(0, 5, 6);
        wait_grant(base);
        repeat (5) step();
        chk("t5_busy_in_run", 64'(busy), 64'd1);
        reset = 1'b1; mul_rst = 1'b1;
        sbq.delete();
        step();
        #1;
        chk("t5_ctrl_zero", 64'({busy, rsp_valid, rsp_err, mul_start, err_sticky, req_ready}), 64'd0);
        chk("t5_data_zero", 64'({mul_a, mul_b}), 64'd0);
        chk("t5_result_zero", 64'(rsp_result), 64'd0);
        @(negedge clk);
        reset = 1'b0; mul_rst = 1'b0;
        r0 = rsp_cnt;
        repeat (25) step();
        chk("t5_no_rsp", 64'(rsp_cnt - r0), 64'd0);
        req1(0, 5, 6);
        drain(100);
        chk("t5_after_reset", 64'(last_res), 64'd30);

        // Requester 2 pulses during busy and is skipped; 1 is served; ptr lands on 2.
        base = grant_log.size();
        req1(0, 2, 3);
        wait_grant(base);
        req1(1, 4, 5);
        req1(2, 9, 9);
        repeat (3) step();
        req_valid[2] = 1'b0;
        drain(100);
        chk("t6_grant0", 64'(grant_log[base]), 64'd0);
        chk("t6_grant1", 64'(grant_log[$]), 64'd1);
        chk("t6_grant_count", 64'(grant_log.size() - base), 64'd2);
        base = grant_log.size();
        req1(0, 1, 2); req1(2, 3, 4); req1(3, 5, 6);
        drain(300);
        if (grant_log.size() >= base + 3) begin
            chk("t6_ptr_first", 64'(grant_log[base]),     64'd2);
            chk("t6_ptr_next",  64'(grant_log[base + 1]), 64'd3);
            chk("t6_ptr_wrap",  64'(grant_log[base + 2]), 64'd0);
        end else begin
            chk("t6_ptr_grants", 64'(grant_log.size() - base), 64'd3);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
